// File: rtl/bottsum_pkg.sv
// Shared types and constants for the BCD sum counter sequencer.
// State encoding here is the one exported on state_o.
package bottsum_pkg;

   localparam int         BCD_W         = 4;
   localparam int         CLR_PULSES    = 2;
   localparam logic [7:0] LIMIT_BCD_DEF = 8'h99;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_PAUSE    = 3'd2,
      ST_OVER     = 3'd3,
      ST_CLR1     = 3'd4,
      ST_CLR_GAP  = 3'd5,
      ST_CLR2     = 3'd6,
      ST_CLR_WAIT = 3'd7
   } state_e;

   function automatic logic is_clr_state(input state_e s);
      return (s == ST_CLR1) || (s == ST_CLR_GAP) || (s == ST_CLR2) || (s == ST_CLR_WAIT);
   endfunction

endpackage

// File: rtl/bottsum_ctrl_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick_o on the
// terminal count and wraps; clr_i forces the count back to zero.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && !clr_i && (cnt_q == TC);

endmodule

// File: rtl/bottsum_ctrl.sv
// Sequencer for the two-digit BCD sum counter: run/pause/over control, tick
// timing and the two-pulse clear handshake. Optional macro: BOTTSUM_AUTO_CLEAR_EN.
module bottsum_ctrl
   import bottsum_pkg::*;
#(
   parameter int         TICK_DIV   = 50_000_000,
   parameter logic [7:0] LIMIT_BCD  = LIMIT_BCD_DEF,
   parameter int         CLR_TMO    = 8,
   parameter int         HOLD_TICKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_start,
   input  logic             btn_stop,
   input  logic             btn_clr,
   input  logic [BCD_W-1:0] num3_1,
   input  logic [BCD_W-1:0] num2_1,
   input  logic             change,
   output logic             cnt_start,
   output logic             cnt_allow_start,
   output logic             cnt_stop,
   output logic             cnt_over,
   output logic [2:0]       state_o,
   output logic             clr_err
);

   // One wait counter serves both the clear timeout and the OVER hold period.
   localparam int            WAIT_MAX  = (CLR_TMO > HOLD_TICKS) ? CLR_TMO : HOLD_TICKS;
   localparam int            WW        = $clog2(WAIT_MAX + 1);
   localparam logic [WW-1:0] TMO_LAST  = WW'(CLR_TMO - 1);
`ifdef BOTTSUM_AUTO_CLEAR_EN
   localparam logic [WW-1:0] HOLD_LAST = WW'(HOLD_TICKS - 1);
`endif

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          clr_err_q, clr_err_d;
   logic          clr_pend_q, clr_pend_d;
   logic          start_q, start_d;
   logic          allow_q, allow_d;
   logic          stop_q, stop_d;
   logic          over_q, over_d;

   logic ps_en;
   logic ps_clr;
   logic tick;
   logic tick_out;
   logic clr_req;
   logic at_limit;

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (ps_en),
      .clr_i (ps_clr),
      .tick_o(tick)
   );

   assign at_limit = ({num3_1, num2_1} == LIMIT_BCD);
   // A clear arriving while a tick pulse is on the wire is deferred one
   // cycle so cnt_start never stays high on two consecutive cycles.
   assign clr_req  = btn_clr || clr_pend_q;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      clr_err_d  = clr_err_q;
      clr_pend_d = 1'b0;
      tick_out   = 1'b0;
      ps_en      = 1'b0;
      ps_clr     = 1'b0;

      if (!is_clr_state(state_q)) begin
         clr_pend_d = clr_req && start_q;
         if (btn_start) begin
            clr_err_d = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            ps_clr = 1'b1;
            if (clr_req) begin
               if (!start_q) state_d = ST_CLR1;
            end else if (btn_start && !btn_stop) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            ps_en = 1'b1;
            if (clr_req) begin
               if (!start_q) state_d = ST_CLR1;
            end else if (tick && at_limit) begin
               state_d = ST_OVER;
            end else begin
               tick_out = tick;
               if (btn_stop) state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (clr_req) begin
               if (!start_q) state_d = ST_CLR1;
            end else if (btn_start && !btn_stop) begin
               state_d = ST_RUN;
            end
         end
         ST_OVER: begin
`ifdef BOTTSUM_AUTO_CLEAR_EN
            ps_en = 1'b1;
            if (clr_req) begin
               if (!start_q) state_d = ST_CLR1;
            end else if (tick) begin
               if (wait_q == HOLD_LAST) state_d = ST_CLR1;
               else                     wait_d  = wait_q + 1'b1;
            end
`else
            if (clr_req && !start_q) state_d = ST_CLR1;
`endif
         end
         ST_CLR1: begin
            ps_clr  = 1'b1;
            state_d = ST_CLR_GAP;
         end
         ST_CLR_GAP: begin
            ps_clr  = 1'b1;
            state_d = ST_CLR2;
         end
         ST_CLR2: begin
            ps_clr  = 1'b1;
            state_d = change ? ST_IDLE : ST_CLR_WAIT;
         end
         ST_CLR_WAIT: begin
            ps_clr = 1'b1;
            if (change) begin
               state_d = ST_IDLE;
            end else if (wait_q == TMO_LAST) begin
               state_d   = ST_IDLE;
               clr_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
         wait_d = '0;
      end

      // Outputs are registered from the next state so they line up with state_o.
      start_d = tick_out || (state_d == ST_CLR1) || (state_d == ST_CLR2);
      allow_d = start_d;
      stop_d  = (state_d == ST_CLR1) || (state_d == ST_CLR2);
      over_d  = (state_d == ST_OVER);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         clr_err_q  <= 1'b0;
         clr_pend_q <= 1'b0;
         start_q    <= 1'b0;
         allow_q    <= 1'b0;
         stop_q     <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         clr_err_q  <= clr_err_d;
         clr_pend_q <= clr_pend_d;
         start_q    <= start_d;
         allow_q    <= allow_d;
         stop_q     <= stop_d;
         over_q     <= over_d;
      end
   end

   assign cnt_start       = start_q;
   assign cnt_allow_start = allow_q;
   assign cnt_stop        = stop_q;
   assign cnt_over        = over_q;
   assign state_o         = state_q;
   assign clr_err         = clr_err_q;

endmodule
